// File: rtl/div_share_pkg.sv
// Shared types and widths for the divider-sharing arbiter and its result FIFOs.
package div_share_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 16;
   localparam int QUOT_W     = 16;
   localparam int FRAC_W     = 8;
   localparam int RES_W      = 1 + QUOT_W + FRAC_W;

   localparam logic REQ_CB = 1'b0;
   localparam logic REQ_CR = 1'b1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic valid;
      logic id;
      logic div0;
   } tag_t;

endpackage

// File: rtl/div_share_arbiter_res_fifo.sv
// First-word-fall-through result FIFO; the data output holds the last popped word while empty.
module res_fifo
   import div_share_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = RES_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wrEn,
   input  logic [WIDTH-1:0]         i_wrData,
   input  logic                     i_rdEn,
   output logic [WIDTH-1:0]         o_rdData,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [AW-1:0]     r_wrPtr;
   logic [AW-1:0]     r_rdPtr;
   logic [AW:0]       r_count;
   logic [WIDTH-1:0]  r_last;
   logic              w_pop;

   assign w_pop = i_rdEn & (r_count != '0);

   always_ff @(posedge clk) begin
      if (i_wrEn) r_mem[r_wrPtr] <= i_wrData;
   end

   // Writes are never refused: the arbiter's credit check guarantees space.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_last  <= '0;
      end else begin
         if (i_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
            r_last  <= r_mem[r_rdPtr];
         end
         case ({i_wrEn, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid  = (r_count != '0);
   assign o_rdData = o_valid ? r_mem[r_rdPtr] : r_last;
   assign o_count  = r_count;

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one fixed-latency divider between the Cb and Cr transform paths,
// with tagged in-flight tracking and credit-limited per-requester result FIFOs.
module div_share_arbiter
   import div_share_pkg::*;
#(
   parameter int DIV_LAT   = 20,
   parameter int RES_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DIVIDEND_W-1:0] req0_dividend,
   input  logic [DIVISOR_W-1:0]  req0_divisor,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DIVIDEND_W-1:0] req1_dividend,
   input  logic [DIVISOR_W-1:0]  req1_divisor,
   input  logic                  div_rfd,
   output logic                  div_nd,
   output logic [DIVIDEND_W-1:0] div_dividend,
   output logic [DIVISOR_W-1:0]  div_divisor,
   input  logic [QUOT_W-1:0]     div_quotient,
   input  logic [FRAC_W-1:0]     div_fractional,
   output logic                  res0_valid,
   input  logic                  res0_ready,
   output logic [QUOT_W-1:0]     res0_quotient,
   output logic [FRAC_W-1:0]     res0_fractional,
   output logic                  res0_div0,
   output logic                  res1_valid,
   input  logic                  res1_ready,
   output logic [QUOT_W-1:0]     res1_quotient,
   output logic [FRAC_W-1:0]     res1_fractional,
   output logic                  res1_div0,
   input  logic                  frame_end,
   output logic                  drain_done,
   output logic                  busy
);

   localparam int CNT_W = $clog2(RES_DEPTH) + 1;

   state_t                r_state;
   state_t                w_nextState;
   logic                  w_drainDoneNext;
   logic                  r_drainDone;
   logic                  r_lastGrant;
   logic [CNT_W-1:0]      r_inflight0;
   logic [CNT_W-1:0]      r_inflight1;
   logic [CNT_W-1:0]      w_count0;
   logic [CNT_W-1:0]      w_count1;
   logic [CNT_W:0]        w_occ0;
   logic [CNT_W:0]        w_occ1;
   logic                  w_elig0;
   logic                  w_elig1;
   logic                  w_grant0;
   logic                  w_grant1;
   logic                  r_nd;
   logic                  r_issueId;
   logic                  r_issueDiv0;
   logic [DIVIDEND_W-1:0] r_dividend;
   logic [DIVISOR_W-1:0]  r_divisor;
   tag_t                  r_tagPipe [DIV_LAT];
   tag_t                  w_wbTag;
   logic                  w_wr0;
   logic                  w_wr1;
   logic [RES_W-1:0]      w_wrData;
   logic [RES_W-1:0]      w_rd0;
   logic [RES_W-1:0]      w_rd1;

   // A requester may only issue while its queued plus in-flight results fit in its FIFO.
   assign w_occ0  = {1'b0, w_count0} + {1'b0, r_inflight0};
   assign w_occ1  = {1'b0, w_count1} + {1'b0, r_inflight1};
   assign w_elig0 = ~rst & req0_valid & div_rfd & (r_state != DRAIN)
                    & (w_occ0 < (CNT_W+1)'(RES_DEPTH));
   assign w_elig1 = ~rst & req1_valid & div_rfd & (r_state != DRAIN)
                    & (w_occ1 < (CNT_W+1)'(RES_DEPTH));
   assign w_grant0 = w_elig0 & (~w_elig1 | r_lastGrant);
   assign w_grant1 = w_elig1 & (~w_elig0 | ~r_lastGrant);
   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= REQ_CR;
         r_nd        <= 1'b0;
         r_issueId   <= REQ_CB;
         r_issueDiv0 <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
      end else begin
         r_nd <= w_grant0 | w_grant1;
         if (w_grant0) begin
            r_lastGrant <= REQ_CB;
            r_issueId   <= REQ_CB;
            r_issueDiv0 <= (req0_divisor == '0);
            r_dividend  <= req0_dividend;
            r_divisor   <= req0_divisor;
         end else if (w_grant1) begin
            r_lastGrant <= REQ_CR;
            r_issueId   <= REQ_CR;
            r_issueDiv0 <= (req1_divisor == '0);
            r_dividend  <= req1_dividend;
            r_divisor   <= req1_divisor;
         end
      end
   end

   // The tag leaves the last stage in the same cycle the divider presents its quotient.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIV_LAT; i++) r_tagPipe[i] <= '0;
      end else begin
         r_tagPipe[0] <= '{valid: r_nd, id: r_issueId, div0: r_issueDiv0};
         for (int i = 1; i < DIV_LAT; i++) r_tagPipe[i] <= r_tagPipe[i-1];
      end
   end

   assign w_wbTag  = r_tagPipe[DIV_LAT-1];
   assign w_wr0    = w_wbTag.valid & (w_wbTag.id == REQ_CB);
   assign w_wr1    = w_wbTag.valid & (w_wbTag.id == REQ_CR);
   assign w_wrData = w_wbTag.div0 ? {1'b1, 16'hFFFF, 8'h00}
                                  : {1'b0, div_quotient, div_fractional};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight0 <= '0;
         r_inflight1 <= '0;
         r_state     <= IDLE;
         r_drainDone <= 1'b0;
      end else begin
         r_inflight0 <= r_inflight0 + CNT_W'(w_grant0) - CNT_W'(w_wr0);
         r_inflight1 <= r_inflight1 + CNT_W'(w_grant1) - CNT_W'(w_wr1);
         r_state     <= w_nextState;
         r_drainDone <= w_drainDoneNext;
      end
   end

   always_comb begin
      w_nextState     = r_state;
      w_drainDoneNext = 1'b0;
      busy            = (r_state == RUN) || (r_state == DRAIN);
      case (r_state)
         IDLE: begin
            if (frame_end) w_drainDoneNext = 1'b1;
            else if (req0_valid | req1_valid) w_nextState = RUN;
         end
         RUN: begin
            if (frame_end) w_nextState = DRAIN;
         end
         DRAIN: begin
            if ((r_inflight0 == '0) && (r_inflight1 == '0)
                && (w_count0 == '0) && (w_count1 == '0)) begin
               w_nextState     = IDLE;
               w_drainDoneNext = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign drain_done   = r_drainDone;
   assign div_nd       = r_nd;
   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;

   res_fifo #(.DEPTH(RES_DEPTH), .WIDTH(RES_W)) u_res0 (
      .clk      (clk),
      .rst      (rst),
      .i_wrEn   (w_wr0),
      .i_wrData (w_wrData),
      .i_rdEn   (res0_ready),
      .o_rdData (w_rd0),
      .o_valid  (res0_valid),
      .o_count  (w_count0)
   );

   res_fifo #(.DEPTH(RES_DEPTH), .WIDTH(RES_W)) u_res1 (
      .clk      (clk),
      .rst      (rst),
      .i_wrEn   (w_wr1),
      .i_wrData (w_wrData),
      .i_rdEn   (res1_ready),
      .o_rdData (w_rd1),
      .o_valid  (res1_valid),
      .o_count  (w_count1)
   );

   assign {res0_div0, res0_quotient, res0_fractional} = w_rd0;
   assign {res1_div0, res1_quotient, res1_fractional} = w_rd1;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: a divider stand-in, a queue-based reference model checked every
// cycle, and directed/random stimulus with a few hand-computed expectations.
module tb_div_share_arbiter;

   localparam int DIV_LAT   = 20;
   localparam int RES_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_dividend = '0, req0_divisor = '0;
   logic [15:0] req1_dividend = '0, req1_divisor = '0;
   logic        div_rfd = 1'b1;
   logic        div_nd;
   logic [15:0] div_dividend, div_divisor;
   logic [15:0] div_quotient = '0;
   logic [7:0]  div_fractional = '0;
   logic        res0_valid, res1_valid;
   logic        res0_ready = 1'b0, res1_ready = 1'b0;
   logic [15:0] res0_quotient, res1_quotient;
   logic [7:0]  res0_fractional, res1_fractional;
   logic        res0_div0, res1_div0;
   logic        frame_end = 1'b0;
   logic        drain_done, busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   div_share_arbiter #(.DIV_LAT(DIV_LAT), .RES_DEPTH(RES_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
      .div_rfd(div_rfd), .div_nd(div_nd),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_fractional(div_fractional),
      .res0_valid(res0_valid), .res0_ready(res0_ready),
      .res0_quotient(res0_quotient), .res0_fractional(res0_fractional), .res0_div0(res0_div0),
      .res1_valid(res1_valid), .res1_ready(res1_ready),
      .res1_quotient(res1_quotient), .res1_fractional(res1_fractional), .res1_div0(res1_div0),
      .frame_end(frame_end), .drain_done(drain_done), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference result word {div0, quotient, fraction}; fraction is floor(remainder*256/divisor).
   function automatic logic [24:0] calcWord(input logic [15:0] a, input logic [15:0] b);
      int unsigned ai;
      int unsigned bi;
      ai = a;
      bi = b;
      if (bi == 0) return {1'b1, 16'hFFFF, 8'h00};
      return {1'b0, 16'(ai / bi), 8'(((ai % bi) * 256) / bi)};
   endfunction

   typedef struct {int wbCycle; logic id; logic [24:0] word;} pend_t;
   typedef struct {int cyc; logic [15:0] q; logic [7:0] f;} dq_t;

   pend_t       pend[$];
   dq_t         dq[$];
   logic [24:0] fq0[$];
   logic [24:0] fq1[$];
   logic [24:0] last0 = '0, last1 = '0;
   int          mState = 0;
   logic        lastGrant = 1'b1;
   logic        expNd = 1'b0;
   logic [15:0] expDvd = '0, expDvs = '0;
   logic        expDrainDone = 1'b0;

   task automatic modelStep();
      int   i0, i1, nextState;
      logic e0, e1, g0, g1, drainNext, allEmpty;
      logic [24:0] w;
      if (rst) begin
         checkOutput("reset_ctrl", {req0_ready, req1_ready, div_nd, div_dividend, div_divisor,
                                    drain_done, busy}, '0);
         checkOutput("reset_res", {res0_valid, res0_div0, res0_quotient, res0_fractional,
                                   res1_valid, res1_div0, res1_quotient, res1_fractional}, '0);
         pend.delete(); fq0.delete(); fq1.delete();
         last0 = '0; last1 = '0; mState = 0; lastGrant = 1'b1;
         expNd = 1'b0; expDrainDone = 1'b0;
         return;
      end
      i0 = 0; i1 = 0;
      foreach (pend[k]) if (pend[k].id) i1++; else i0++;
      e0 = req0_valid && div_rfd && mState != 2 && (fq0.size() + i0 < RES_DEPTH);
      e1 = req1_valid && div_rfd && mState != 2 && (fq1.size() + i1 < RES_DEPTH);
      g0 = 1'b0; g1 = 1'b0;
      if (e0 && e1) begin
         if (lastGrant) g0 = 1'b1; else g1 = 1'b1;
      end else begin
         g0 = e0;
         g1 = e1;
      end
      checkOutput("req0_ready", req0_ready, g0);
      checkOutput("req1_ready", req1_ready, g1);
      checkOutput("div_nd", div_nd, expNd);
      if (expNd) checkOutput("div_operands", {div_dividend, div_divisor}, {expDvd, expDvs});
      checkOutput("res0_valid", res0_valid, fq0.size() > 0);
      checkOutput("res0_word", {res0_div0, res0_quotient, res0_fractional},
                  fq0.size() > 0 ? fq0[0] : last0);
      checkOutput("res1_valid", res1_valid, fq1.size() > 0);
      checkOutput("res1_word", {res1_div0, res1_quotient, res1_fractional},
                  fq1.size() > 0 ? fq1[0] : last1);
      checkOutput("busy", busy, mState != 0);
      checkOutput("drain_done", drain_done, expDrainDone);

      if (div_nd) begin
         w = calcWord(div_dividend, div_divisor);
         if (div_divisor == 0) w = 25'($urandom);
         dq.push_back('{cyc: cycle + DIV_LAT, q: w[23:8], f: w[7:0]});
      end

      allEmpty  = (pend.size() == 0) && (fq0.size() == 0) && (fq1.size() == 0);
      drainNext = 1'b0;
      nextState = mState;
      if (mState == 0) begin
         if (frame_end) drainNext = 1'b1;
         else if (req0_valid || req1_valid) nextState = 1;
      end else if (mState == 1) begin
         if (frame_end) nextState = 2;
      end else if (allEmpty) begin
         nextState = 0;
         drainNext = 1'b1;
      end

      if (res0_ready && fq0.size() > 0) last0 = fq0.pop_front();
      if (res1_ready && fq1.size() > 0) last1 = fq1.pop_front();
      while (pend.size() > 0 && pend[0].wbCycle == cycle) begin
         if (pend[0].id) fq1.push_back(pend[0].word);
         else            fq0.push_back(pend[0].word);
         void'(pend.pop_front());
      end

      expNd = g0 || g1;
      if (g0) begin
         pend.push_back('{wbCycle: cycle + 1 + DIV_LAT, id: 1'b0,
                          word: calcWord(req0_dividend, req0_divisor)});
         expDvd = req0_dividend; expDvs = req0_divisor; lastGrant = 1'b0;
      end else if (g1) begin
         pend.push_back('{wbCycle: cycle + 1 + DIV_LAT, id: 1'b1,
                          word: calcWord(req1_dividend, req1_divisor)});
         expDvd = req1_dividend; expDvs = req1_divisor; lastGrant = 1'b1;
      end
      mState       = nextState;
      expDrainDone = drainNext;
   endtask

   // Divider stand-in drives its outputs at +1; the model samples and advances at +3.
   initial begin
      forever begin
         @(posedge clk);
         cycle++;
         #1;
         while (dq.size() > 0 && dq[0].cyc < cycle) void'(dq.pop_front());
         if (dq.size() > 0 && dq[0].cyc == cycle) begin
            div_quotient   = dq[0].q;
            div_fractional = dq[0].f;
            void'(dq.pop_front());
         end else begin
            div_quotient   = 16'($urandom);
            div_fractional = 8'($urandom);
         end
         #2;
         modelStep();
      end
   end

   task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                                input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                                input logic rfd, input logic r0, input logic r1, input logic fe);
      @(posedge clk);
      #1;
      req0_valid = v0; req0_dividend = a0; req0_divisor = b0;
      req1_valid = v1; req1_dividend = a1; req1_divisor = b1;
      div_rfd = rfd; res0_ready = r0; res1_ready = r1; frame_end = fe;
   endtask

   task automatic issue0(input logic [15:0] a, input logic [15:0] b, input logic r0,
                         input string tag);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         applyStimulus(1, a, b, 0, 0, 0, 1, r0, 1, 0);
         #1;
         got = req0_ready;
      end
      checkOutput({tag, "_accept"}, got, 1);
   endtask

   task automatic idle(input int n, input logic r0, input logic r1);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1, r0, r1, 0);
   endtask

   initial begin
      int          acc0, acc1, acceptCycle;
      logic        seen;
      logic [15:0] expQ [3];
      logic [7:0]  expF [3];
      logic        expZ [3];

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] single request");
      applyStimulus(1, 16'd10000, 16'd100, 0, 0, 0, 1, 0, 0, 0);
      #1;
      checkOutput("t1_accept", req0_ready, 1);
      acceptCycle = cycle;
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      #1;
      checkOutput("t1_nd_after_accept", div_nd, 1);
      seen = 1'b0;
      for (int k = 0; k < DIV_LAT + 10 && !seen; k++) begin
         @(posedge clk);
         #2;
         seen = res0_valid;
      end
      checkOutput("t1_latency", cycle - acceptCycle, DIV_LAT + 2);
      checkOutput("t1_quotient", res0_quotient, 16'd100);
      checkOutput("t1_fraction", res0_fractional, 8'd0);
      checkOutput("t1_div0", res0_div0, 0);
      idle(3, 1, 1);

      $display("[TB] both requesters streaming");
      acc0 = 0; acc1 = 0;
      for (int k = 0; k < 40 && (acc0 < 8 || acc1 < 8); k++) begin
         applyStimulus(acc0 < 8, 16'($urandom), 16'($urandom), acc1 < 8, 16'($urandom),
                       16'($urandom), 1, 1, 1, 0);
         #1;
         if (req0_ready) acc0++;
         if (req1_ready) acc1++;
      end
      checkOutput("t2_accepts", acc0 + acc1, 16);
      idle(30, 1, 1);

      $display("[TB] result FIFO backpressure");
      acc0 = 0; acc1 = 0;
      for (int k = 0; k < 60; k++) begin
         applyStimulus(1, 16'($urandom), 16'($urandom_range(65535, 1)), 1, 16'($urandom),
                       16'($urandom_range(65535, 1)), 1, 1, 0, 0);
         #1;
         if (req0_ready) acc0++;
         if (req1_ready) acc1++;
      end
      checkOutput("t3_req1_accepts", acc1, RES_DEPTH);
      checkOutput("t3_req0_flowing", acc0 > RES_DEPTH, 1);
      idle(40, 1, 1);

      $display("[TB] divide by zero ordering");
      expQ[0] = 16'd71;    expF[0] = 8'd109; expZ[0] = 1'b0;
      expQ[1] = 16'hFFFF;  expF[1] = 8'h00;  expZ[1] = 1'b1;
      expQ[2] = 16'd3;     expF[2] = 8'd0;   expZ[2] = 1'b0;
      issue0(16'd500, 16'd7, 0, "t4_op0");
      issue0(16'd1234, 16'd0, 0, "t4_op1");
      issue0(16'd9, 16'd3, 0, "t4_op2");
      idle(30, 0, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
         #1;
         checkOutput("t4_head_valid", res0_valid, 1);
         checkOutput("t4_head_word", {res0_div0, res0_quotient, res0_fractional},
                     {expZ[k], expQ[k], expF[k]});
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      end
      idle(3, 1, 1);

      $display("[TB] frame end with work in flight");
      issue0(16'd4000, 16'd3, 1, "t5_op0");
      issue0(16'd65535, 16'd255, 1, "t5_op1");
      issue0(16'd77, 16'd78, 1, "t5_op2");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      acc1 = 0;
      for (int k = 0; k < 25; k++) begin
         applyStimulus(0, 0, 0, 1, 16'd5, 16'd5, 1, 0, 1, 0);
         #1;
         if (req1_ready) acc1++;
      end
      checkOutput("t5_drain_refuses", acc1, 0);
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
         #1;
         seen = drain_done;
      end
      checkOutput("t5_drain_done", seen, 1);
      checkOutput("t5_busy_after_drain", busy, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      #1;
      checkOutput("idle_frame_end_done", drain_done, 1);
      checkOutput("idle_frame_end_busy", busy, 0);

      $display("[TB] reset with work in flight");
      for (int k = 0; k < 10; k++)
         applyStimulus(1, 16'($urandom), 16'($urandom), 1, 16'($urandom), 16'($urandom),
                       1, 1, 1, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("t6_nd_cleared", div_nd, 0);
      checkOutput("t6_busy_cleared", busy, 0);
      checkOutput("t6_ready_cleared", {req0_ready, req1_ready}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] random traffic");
      for (int k = 0; k < 500; k++) begin
         applyStimulus($urandom_range(1, 0) == 1, 16'($urandom),
                       ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom),
                       $urandom_range(1, 0) == 1, 16'($urandom_range(2000, 0)),
                       ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom_range(300, 0)),
                       $urandom_range(4, 0) != 0, $urandom_range(4, 0) < 3,
                       $urandom_range(4, 0) < 3, $urandom_range(39, 0) == 0);
      end
      idle(60, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
